// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP transmit scheduler.
package arp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_REQ,
    ST_FIRE_REQ,
    ST_LOAD_REPLY,
    ST_FRAME,
    ST_RESOLVE_WAIT
  } arp_state_t;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_WAIT_START,
    TRK_IN_FRAME,
    TRK_GAP
  } trk_state_t;

  localparam logic [15:0] ARP_OP_REQ   = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY = 16'd2;

  localparam logic [31:0] ARP_IP_NONE  = 32'h0000_0000;

  // Down-counters expire on the cycle they read zero, so load N-1 for N cycles.
  function automatic logic [31:0] cyc_to_load(input logic [31:0] cyc);
    return (cyc == 32'd0) ? 32'd0 : cyc - 32'd1;
  endfunction

endpackage

// File: rtl/arp_tx_ctrl_if.sv
// Upstream/framer-facing signal bundle of the ARP transmit scheduler.
interface arp_tx_ctrl_if;
  logic        i_reply_req;
  logic        i_resolve_req;
  logic [31:0] i_resolve_ip;
  logic        i_arp_reply_valid;
  logic [31:0] i_arp_reply_ip;
  logic        i_mac_valid;
  logic        o_trig_reply;
  logic        o_active_req;
  logic [31:0] o_dst_ip;
  logic        o_dst_ip_valid;
  logic        o_busy;
  logic        o_resolve_ok;
  logic        o_resolve_fail;

  modport slave (
    input  i_reply_req, i_resolve_req, i_resolve_ip,
    input  i_arp_reply_valid, i_arp_reply_ip, i_mac_valid,
    output o_trig_reply, o_active_req, o_dst_ip, o_dst_ip_valid,
    output o_busy, o_resolve_ok, o_resolve_fail
  );

  modport master (
    output i_reply_req, i_resolve_req, i_resolve_ip,
    output i_arp_reply_valid, i_arp_reply_ip, i_mac_valid,
    input  o_trig_reply, o_active_req, o_dst_ip, o_dst_ip_valid,
    input  o_busy, o_resolve_ok, o_resolve_fail
  );
endinterface

// File: rtl/arp_frame_tracker.sv
// Follows one framer transmission: start window, valid-high body, inter-frame gap.
// state          | meaning
// TRK_IDLE       | no frame outstanding
// TRK_WAIT_START | trigger sent, waiting for framer valid (bounded)
// TRK_IN_FRAME   | framer valid high
// TRK_GAP        | enforced idle after the frame, then frame_done
module arp_frame_tracker
  import arp_pkg::*;
#(
  parameter logic [7:0] P_START_TO = 8'd8,
  parameter logic [7:0] P_IFG_CYC  = 8'd12
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_mac_valid,
  output logic o_frame_done
);

  localparam logic [7:0] LP_START_LD = (P_START_TO == 8'd0) ? 8'd0 : P_START_TO - 8'd1;
  localparam logic [7:0] LP_IFG_LD   = (P_IFG_CYC == 8'd0) ? 8'd0 : P_IFG_CYC - 8'd1;

  trk_state_t r_state;
  logic [7:0] r_cnt;
  logic       r_frame_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= TRK_IDLE;
      r_cnt        <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        TRK_IDLE: begin
          if (i_start) begin
            r_state <= TRK_WAIT_START;
            r_cnt   <= LP_START_LD;
          end
        end
        TRK_WAIT_START: begin
          if (i_mac_valid) begin
            r_state <= TRK_IN_FRAME;
          end else if (r_cnt == 8'd0) begin
            // framer never started; treat the frame as finished
            r_state <= TRK_GAP;
            r_cnt   <= LP_IFG_LD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        TRK_IN_FRAME: begin
          if (!i_mac_valid) begin
            r_state <= TRK_GAP;
            r_cnt   <= LP_IFG_LD;
          end
        end
        TRK_GAP: begin
          if (r_cnt == 8'd0) begin
            r_state      <= TRK_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= TRK_IDLE;
      endcase
    end
  end

  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP transmit scheduler: arbitrates replies and resolve requests, one frame at a time.
// state           | meaning
// ST_IDLE         | nothing in flight; pick reply first, then request
// ST_LOAD_REQ     | destination IP strobed to framer
// ST_FIRE_REQ     | request trigger pulse
// ST_LOAD_REPLY   | reply trigger pulse
// ST_FRAME        | frame tracker running (start window, body, gap)
// ST_RESOLVE_WAIT | awaiting matching ARP reply, response timer running
module arp_tx_ctrl
  import arp_pkg::*;
#(
  parameter logic [31:0] P_TIMEOUT_CYC = 32'd125_000_000,
  parameter logic [3:0]  P_MAX_RETRY   = 4'd3,
  parameter logic [7:0]  P_IFG_CYC     = 8'd12,
  parameter logic [7:0]  P_START_TO    = 8'd8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  arp_tx_ctrl_if.slave  if_arp
);

  localparam logic [31:0] LP_TMR_LD = cyc_to_load(P_TIMEOUT_CYC);

  arp_state_t  r_state;
  logic        r_reply_pend;
  logic        r_req_pend;
  logic        r_resolve_act;
  logic [31:0] r_tgt_ip;
  logic [3:0]  r_retry;
  logic [31:0] r_resp_tmr;
  logic [15:0] r_cur_op;
  logic        r_trig_reply;
  logic        r_active_req;
  logic [31:0] r_dst_ip;
  logic        r_dst_ip_valid;
  logic        r_resolve_ok;
  logic        r_resolve_fail;

  logic        w_match;
  logic        w_req_busy;
  logic        w_frame_done;

  assign w_match = r_resolve_act && if_arp.i_arp_reply_valid &&
                   (if_arp.i_arp_reply_ip == r_tgt_ip);

  // The response timer is held while our own request is being sent.
  assign w_req_busy = (r_cur_op == ARP_OP_REQ) &&
                      (r_state inside {ST_LOAD_REQ, ST_FIRE_REQ, ST_FRAME});

  arp_frame_tracker #(
    .P_START_TO (P_START_TO),
    .P_IFG_CYC  (P_IFG_CYC)
  ) u_tracker (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (r_trig_reply | r_active_req),
    .i_mac_valid  (if_arp.i_mac_valid),
    .o_frame_done (w_frame_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_reply_pend   <= 1'b0;
      r_req_pend     <= 1'b0;
      r_resolve_act  <= 1'b0;
      r_tgt_ip       <= ARP_IP_NONE;
      r_retry        <= 4'd0;
      r_resp_tmr     <= LP_TMR_LD;
      r_cur_op       <= ARP_OP_REPLY;
      r_trig_reply   <= 1'b0;
      r_active_req   <= 1'b0;
      r_dst_ip       <= ARP_IP_NONE;
      r_dst_ip_valid <= 1'b0;
      r_resolve_ok   <= 1'b0;
      r_resolve_fail <= 1'b0;
    end else begin
      r_trig_reply   <= 1'b0;
      r_active_req   <= 1'b0;
      r_dst_ip_valid <= 1'b0;
      r_resolve_ok   <= 1'b0;
      r_resolve_fail <= 1'b0;

      if (if_arp.i_resolve_req && !r_resolve_act) begin
        r_tgt_ip      <= if_arp.i_resolve_ip;
        r_req_pend    <= 1'b1;
        r_resolve_act <= 1'b1;
        r_retry       <= 4'd0;
      end

      if (!r_resolve_act || w_req_busy) begin
        r_resp_tmr <= LP_TMR_LD;
      end else if (r_resp_tmr != 32'd0) begin
        r_resp_tmr <= r_resp_tmr - 32'd1;
      end

      if (w_match) begin
        r_resolve_ok  <= 1'b1;
        r_resolve_act <= 1'b0;
        r_req_pend    <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_reply_pend) begin
            r_state      <= ST_LOAD_REPLY;
            r_trig_reply <= 1'b1;
            r_reply_pend <= 1'b0;
            r_cur_op     <= ARP_OP_REPLY;
          end else if (r_req_pend) begin
            r_state        <= ST_LOAD_REQ;
            r_dst_ip       <= r_tgt_ip;
            r_dst_ip_valid <= 1'b1;
            r_req_pend     <= 1'b0;
            r_cur_op       <= ARP_OP_REQ;
          end
        end
        ST_LOAD_REQ: begin
          r_state      <= ST_FIRE_REQ;
          r_active_req <= 1'b1;
        end
        ST_FIRE_REQ:   r_state <= ST_FRAME;
        ST_LOAD_REPLY: r_state <= ST_FRAME;
        ST_FRAME: begin
          // a resolve whose first request is still queued goes back through IDLE
          if (w_frame_done) begin
            r_state <= (r_resolve_act && !r_req_pend && !w_match) ? ST_RESOLVE_WAIT : ST_IDLE;
          end
        end
        ST_RESOLVE_WAIT: begin
          if (w_match) begin
            r_state <= ST_IDLE;
          end else if (r_resp_tmr == 32'd0) begin
            if (r_retry < P_MAX_RETRY) begin
              r_retry        <= r_retry + 4'd1;
              r_state        <= ST_LOAD_REQ;
              r_dst_ip       <= r_tgt_ip;
              r_dst_ip_valid <= 1'b1;
              r_cur_op       <= ARP_OP_REQ;
            end else begin
              r_resolve_fail <= 1'b1;
              r_resolve_act  <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end else if (r_reply_pend) begin
            r_state      <= ST_LOAD_REPLY;
            r_trig_reply <= 1'b1;
            r_reply_pend <= 1'b0;
            r_cur_op     <= ARP_OP_REPLY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // a reply request arriving as the previous one fires stays pending
      if (if_arp.i_reply_req) begin
        r_reply_pend <= 1'b1;
      end
    end
  end

  assign if_arp.o_trig_reply   = r_trig_reply;
  assign if_arp.o_active_req   = r_active_req;
  assign if_arp.o_dst_ip       = r_dst_ip;
  assign if_arp.o_dst_ip_valid = r_dst_ip_valid;
  assign if_arp.o_busy         = r_resolve_act;
  assign if_arp.o_resolve_ok   = r_resolve_ok;
  assign if_arp.o_resolve_fail = r_resolve_fail;

endmodule

// File: tb/tb_arp_tx_ctrl.sv
// Directed bench for arp_tx_ctrl: vector table plus multi-cycle scenarios with a framer model.
module tb_arp_tx_ctrl;

  logic clk;
  logic rst;

  arp_tx_ctrl_if ifc ();

  arp_tx_ctrl #(
    .P_TIMEOUT_CYC (32'd100),
    .P_MAX_RETRY   (4'd2),
    .P_IFG_CYC     (8'd12),
    .P_START_TO    (8'd8)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_arp (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          pre;
    logic        rr;
    logic        sr;
    logic [31:0] sip;
    logic        av;
    logic [31:0] aip;
    logic        e_trig;
    logic        e_act;
    logic        e_dv;
    logic [31:0] e_dst;
    logic        e_busy;
    logic        e_ok;
    logic        e_fail;
  } vec_t;

  vec_t vecs [12];

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0, n_trig = 0, n_act = 0, n_ok = 0, n_failp = 0;
  int last_trig_cyc = 0, last_act_cyc = 0, last_fail_cyc = 0, fall_cyc = 0;
  logic prev_valid = 1'b0;

  int fr_cnt = 0;
  bit fr_stuck = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int val, input int lo, input int hi);
    n_chk++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, val, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic idle_in();
    ifc.i_reply_req       = 1'b0;
    ifc.i_resolve_req     = 1'b0;
    ifc.i_resolve_ip      = 32'h0;
    ifc.i_arp_reply_valid = 1'b0;
    ifc.i_arp_reply_ip    = 32'h0;
  endtask

  // Event monitor, samples 1 ns after each edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.o_trig_reply)   begin n_trig++;  last_trig_cyc = cyc; end
    if (ifc.o_active_req)   begin n_act++;   last_act_cyc  = cyc; end
    if (ifc.o_resolve_ok)   n_ok++;
    if (ifc.o_resolve_fail) begin n_failp++; last_fail_cyc = cyc; end
    if (prev_valid && !ifc.i_mac_valid) fall_cyc = cyc;
    prev_valid = ifc.i_mac_valid;
  end

  // Framer model: valid high for 20 cycles starting the cycle after a trigger.
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      fr_cnt = 0;
      ifc.i_mac_valid = 1'b0;
    end else if (fr_cnt > 0) begin
      fr_cnt--;
      if (fr_cnt == 0) ifc.i_mac_valid = 1'b0;
    end else if ((ifc.o_trig_reply || ifc.o_active_req) && !fr_stuck) begin
      ifc.i_mac_valid = 1'b1;
      fr_cnt = 20;
    end else begin
      ifc.i_mac_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           pre rr sr sip           av aip           trg act dv dst           bsy ok fail
    vecs[0]  = '{0,  0, 1, 32'hC0A80A02, 0, 32'h0,        0,  0,  0, 32'h0,        1,  0, 0};
    vecs[1]  = '{0,  0, 0, 32'h0,        0, 32'h0,        0,  0,  1, 32'hC0A80A02, 1,  0, 0};
    vecs[2]  = '{0,  0, 0, 32'h0,        0, 32'h0,        0,  1,  0, 32'hC0A80A02, 1,  0, 0};
    vecs[3]  = '{0,  0, 0, 32'h0,        0, 32'h0,        0,  0,  0, 32'hC0A80A02, 1,  0, 0};
    vecs[4]  = '{40, 0, 0, 32'h0,        1, 32'hC0A80A03, 0,  0,  0, 32'hC0A80A02, 1,  0, 0};
    vecs[5]  = '{20, 0, 0, 32'h0,        1, 32'hC0A80A02, 0,  0,  0, 32'hC0A80A02, 0,  1, 0};
    vecs[6]  = '{0,  0, 0, 32'h0,        0, 32'h0,        0,  0,  0, 32'hC0A80A02, 0,  0, 0};
    vecs[7]  = '{0,  0, 0, 32'h0,        1, 32'hC0A80A02, 0,  0,  0, 32'hC0A80A02, 0,  0, 0};
    vecs[8]  = '{0,  0, 1, 32'h0A000001, 0, 32'h0,        0,  0,  0, 32'hC0A80A02, 1,  0, 0};
    vecs[9]  = '{0,  0, 0, 32'h0,        0, 32'h0,        0,  0,  1, 32'h0A000001, 1,  0, 0};
    vecs[10] = '{0,  0, 1, 32'h0B000002, 0, 32'h0,        0,  1,  0, 32'h0A000001, 1,  0, 0};
    vecs[11] = '{60, 0, 0, 32'h0,        1, 32'h0A000001, 0,  0,  0, 32'h0A000001, 0,  1, 0};

    rst = 1'b1;
    idle_in();
    repeat (3) step();
    chk("rst_trig", ifc.o_trig_reply, 0);
    chk("rst_act", ifc.o_active_req, 0);
    chk("rst_dv", ifc.o_dst_ip_valid, 0);
    chk("rst_dst", ifc.o_dst_ip, 0);
    chk("rst_busy", ifc.o_busy, 0);
    chk("rst_ok", ifc.o_resolve_ok, 0);
    chk("rst_fail", ifc.o_resolve_fail, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      repeat (vecs[i].pre) step();
      ifc.i_reply_req       = vecs[i].rr;
      ifc.i_resolve_req     = vecs[i].sr;
      ifc.i_resolve_ip      = vecs[i].sip;
      ifc.i_arp_reply_valid = vecs[i].av;
      ifc.i_arp_reply_ip    = vecs[i].aip;
      step();
      idle_in();
      chk($sformatf("v%0d_trig", i), ifc.o_trig_reply, vecs[i].e_trig);
      chk($sformatf("v%0d_act", i), ifc.o_active_req, vecs[i].e_act);
      chk($sformatf("v%0d_dv", i), ifc.o_dst_ip_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_dst", i), ifc.o_dst_ip, vecs[i].e_dst);
      chk($sformatf("v%0d_busy", i), ifc.o_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_ok", i), ifc.o_resolve_ok, vecs[i].e_ok);
      chk($sformatf("v%0d_fail", i), ifc.o_resolve_fail, vecs[i].e_fail);
    end
    repeat (5) step();

    // Simultaneous reply and resolve requests: reply goes first, request after gap.
    begin
      int s_tr, s_ac, b;
      s_tr = n_trig; s_ac = n_act; b = 0;
      ifc.i_reply_req = 1'b1; ifc.i_resolve_req = 1'b1; ifc.i_resolve_ip = 32'hC0A80A05;
      step();
      idle_in();
      while (n_act == s_ac && b < 200) begin step(); b++; end
      chk("sim_req_seen", 32'(n_act == s_ac + 1), 1);
      chk("sim_reply_first", 32'(n_trig == s_tr + 1 && last_trig_cyc < last_act_cyc), 1);
      chk_rng("sim_ifg_gap", last_act_cyc - fall_cyc, 12, 20);
      repeat (5) step();
      ifc.i_arp_reply_valid = 1'b1; ifc.i_arp_reply_ip = 32'hC0A80A05;
      step();
      idle_in();
      chk("sim_ok_inflight", ifc.o_resolve_ok, 1);
      chk("sim_busy_clr", ifc.o_busy, 0);
      repeat (60) step();
    end

    // Reply frame during RESOLVE_WAIT must not move the retry deadline.
    begin
      int s_ac, s_tr, t0, b;
      s_ac = n_act; b = 0;
      ifc.i_resolve_req = 1'b1; ifc.i_resolve_ip = 32'hC0A80A06;
      step();
      idle_in();
      while (n_act == s_ac && b < 50) begin step(); b++; end
      chk("rw_first_req", 32'(n_act == s_ac + 1), 1);
      t0 = last_act_cyc;
      repeat (40) step();
      s_tr = n_trig; s_ac = n_act; b = 0;
      ifc.i_reply_req = 1'b1;
      step();
      idle_in();
      while (n_act == s_ac && b < 400) begin step(); b++; end
      chk("rw_retry_seen", 32'(n_act == s_ac + 1), 1);
      chk("rw_reply_sent", 32'(n_trig == s_tr + 1), 1);
      chk_rng("rw_deadline", last_act_cyc - t0, 133, 137);
      ifc.i_arp_reply_valid = 1'b1; ifc.i_arp_reply_ip = 32'hC0A80A06;
      step();
      idle_in();
      chk("rw_ok", ifc.o_resolve_ok, 1);
      repeat (60) step();
    end

    // Stuck framer: start window expires, gap, then the next reply proceeds; requests merge.
    begin
      int s_tr, t1, b;
      fr_stuck = 1'b1;
      s_tr = n_trig; b = 0;
      ifc.i_reply_req = 1'b1;
      step();
      idle_in();
      while (n_trig == s_tr && b < 20) begin step(); b++; end
      chk("stuck_trig1", 32'(n_trig == s_tr + 1), 1);
      t1 = last_trig_cyc;
      ifc.i_reply_req = 1'b1; step(); idle_in(); step();
      ifc.i_reply_req = 1'b1; step(); idle_in();
      b = 0;
      while (n_trig == s_tr + 1 && b < 60) begin step(); b++; end
      chk("stuck_trig2", 32'(n_trig == s_tr + 2), 1);
      chk_rng("stuck_recover", last_trig_cyc - t1, 20, 26);
      repeat (40) step();
      chk("stuck_merge", n_trig - s_tr, 2);
      fr_stuck = 1'b0;
      repeat (5) step();
    end

    // Reset in mid-frame of a retry: everything drops, no done/fail pulse.
    begin
      int s_ac, s_ok, s_f, b;
      s_ac = n_act; b = 0;
      ifc.i_resolve_req = 1'b1; ifc.i_resolve_ip = 32'hC0A80A07;
      step();
      idle_in();
      while (n_act < s_ac + 2 && b < 300) begin step(); b++; end
      chk("mid_retry_seen", 32'(n_act == s_ac + 2), 1);
      repeat (5) step();
      s_ok = n_ok; s_f = n_failp;
      rst = 1'b1;
      step();
      chk("mid_rst_trig", ifc.o_trig_reply, 0);
      chk("mid_rst_act", ifc.o_active_req, 0);
      chk("mid_rst_dv", ifc.o_dst_ip_valid, 0);
      chk("mid_rst_dst", ifc.o_dst_ip, 0);
      chk("mid_rst_busy", ifc.o_busy, 0);
      rst = 1'b0;
      repeat (30) step();
      chk("mid_rst_no_pulse", 32'(n_ok == s_ok && n_failp == s_f), 1);
    end

    // Timeout path after reset: retry count restarts, 3 requests then fail.
    begin
      int s_ac, s_f, t0, b;
      s_ac = n_act; s_f = n_failp; b = 0;
      ifc.i_resolve_req = 1'b1; ifc.i_resolve_ip = 32'hC0A80A08;
      step();
      idle_in();
      while (n_act == s_ac && b < 50) begin step(); b++; end
      chk("to_first_req", 32'(n_act == s_ac + 1), 1);
      chk("to_busy_on", ifc.o_busy, 1);
      t0 = last_act_cyc;
      b = 0;
      while (ifc.o_resolve_fail !== 1'b1 && b < 1500) begin step(); b++; end
      chk("to_fail_seen", ifc.o_resolve_fail, 1);
      chk("to_busy_off", ifc.o_busy, 0);
      chk_rng("to_fail_time", last_fail_cyc - t0, 400, 408);
      chk("to_req_count", n_act - s_ac, 3);
      repeat (20) step();
      chk("to_fail_once", n_failp - s_f, 1);
      chk("to_no_more_req", n_act - s_ac, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
